// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and address width.
// Latency: none (constants only).
// Backpressure: none (constants only).
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;

  // Address width needed to index a storage array of 'depth' entries.
  function automatic int fifo_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FIFO_AW = fifo_addr_w(FIFO_DEPTH);

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: DEPTH x WIDTH registers, one write port, one registered read port.
// Latency: write lands on the clock edge; read data appears one clock after re.
// Backpressure: none; the caller guarantees legal, non-colliding addresses.
//
// Ports:
//   clk            - storage clock
//   we/waddr/wdata - synchronous write port
//   re/raddr       - synchronous read request and address
//   rdata          - registered read data, holds its value while re=0
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array: contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with wrap-parity pointers and registered read data.
// Latency: a read accepted on an edge presents its word on data_out right after that edge.
// Backpressure: writes are dropped while full, reads are ignored while empty; no error flag.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset
//   read     - read request
//   write    - write request, data_in captured when accepted
//   data_in  - write data
//   full     - DEPTH entries stored
//   empty    - no entries stored
//   data_out - last word read, 0 after reset until the first read
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  localparam int AW = fifo_addr_w(DEPTH);

  // One extra MSB per pointer records wrap parity so full and empty are distinguishable.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_en;
  logic             rd_en;
  logic             rd_seen;
  logic [WIDTH-1:0] mem_rdata;

  // Flags derive only from registered pointers, so there is no path from read/write.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Both operations are gated on the pre-edge flags; with read=write=1 an empty
  // FIFO only writes and a full FIFO only reads.
  assign wr_en = write & ~full;
  assign rd_en = read & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_seen <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (rd_en) begin
        rptr    <= rptr + (AW+1)'(1);
        rd_seen <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr[AW-1:0]),
    .wdata (data_in),
    .re    (rd_en),
    .raddr (rptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  // The storage read register has no reset; mask it to zero until a read has
  // been accepted since the last reset, so reset clears data_out immediately.
  assign data_out = rd_seen ? mem_rdata : '0;

endmodule

// File: tb/tb_synchronous_fifo.sv
module tb_synchronous_fifo;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         full;
  logic         empty;
  logic [W-1:0] data_out;

  synchronous_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .data_in  (data_in),
    .full     (full),
    .empty    (empty),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents held as a plain queue, expected read words queued
  // for the monitor, and the value data_out must hold between reads.
  logic [W-1:0] mdl[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last = '0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model applies the FIFO rules to the pre-edge occupancy.
  task automatic step(input bit r, input bit w, input logic [W-1:0] d);
    int sz;
    @(negedge clk);
    #1;
    read    = r;
    write   = w;
    data_in = w ? d : 'x;
    sz = mdl.size();
    if (r && sz != 0) exp_q.push_back(mdl.pop_front());
    if (w && sz != D) mdl.push_back(d);
    @(posedge clk);
    #1;
    read    = 1'b0;
    write   = 1'b0;
    data_in = 'x;
  endtask

  // Reset asserted between clock edges; outputs must respond without a clock.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    mdl.delete();
    exp_q.delete();
    last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: flags every cycle, data_out against the next expected word or the held value.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("empty", empty, (mdl.size() == 0));
        chk("full", full, (mdl.size() == D));
        if (exp_q.size() > 0) last = exp_q.pop_front();
        chk("data_out", data_out, last);
      end
    end
  end

  logic [W-1:0] pat [8];

  initial begin
    pat = '{8'h07, 8'h27, 8'h37, 8'h97, 8'h17, 8'h77, 8'h67, 8'hab};

    // Reset state while reset is held from time zero.
    #2;
    chk("init_data_out", data_out, 0);
    chk("init_empty", empty, 1);
    chk("init_full", full, 0);
    #20;
    @(negedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Fill with the reference pattern, then push while full.
    foreach (pat[i]) step(1'b0, 1'b1, pat[i]);
    repeat (2) step(1'b0, 1'b1, 8'hFF);
    // Drain, plus one read while empty.
    repeat (9) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Four stored, then simultaneous read/write across the pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W'($urandom));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, W'($urandom));
    repeat (5) step(1'b1, 1'b0, '0);

    // Five stored, reset mid-operation, then a write/read pair.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'($urandom));
    mid_reset();
    step(1'b0, 1'b1, 8'h3C);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Empty with read=write=1: only the write goes through.
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Random traffic with shifting bias so both full and empty are reached.
    for (int ph = 0; ph < 6; ph++) begin
      int pr;
      int pw;
      pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 80 : 50;
      pw = 100 - pr;
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < pw), W'($urandom));
      end
    end
    repeat (3) step(1'b0, 1'b0, '0);

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: got %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
